fsm_unlock_sequencer: RTL and testbench
=======================================

// Module: fsm_unlock_sequencer
// PURPOSE
// - Upstream driver for an FSM-locked (obfuscated) design such as test_obf.
// - On start, holds the locked FSM in reset for RST_CYCLES cycles.
// - Then plays the stored unlock key, one IN_W-bit word per cycle, onto the locked FSM's inputs.
// - Then switches to pass-through of functional inputs.
// - Replaces the file-driven unlock stimulus with synthesizable on-chip sequencing.
// PARAMETERS
// - IN_W        2                  width of locked-FSM input bus (line2,line1)
// - KEY_LEN     8                  number of key words; must be >= 1
// - KEY         {KEY_LEN*IN_W{1'b0}}  packed key; step i = KEY[IN_W*i +: IN_W]; step 0 is played first
// - RST_CYCLES  10                 cycles obf_reset is held high after start; must be >= 1
// PORTS
// - clock      in   1     rising-edge clock, shared with the locked FSM
// - reset      in   1     asynchronous, active-high reset
// - start      in   1     request an unlock sequence; sampled each rising edge
// - func_in    in   IN_W  functional inputs, forwarded in PASS state
// - obf_in     out  IN_W  drives locked-FSM inputs (bit0->line1, bit1->line2)
// - obf_reset  out  1     drives locked-FSM reset, active-high
// - busy       out  1     high in RST_HOLD and KEY
// - done       out  1     high in PASS, i.e. the key has been fully applied
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: state=IDLE, obf_in=0, obf_reset=1, busy=0, done=0, counter=0.
// - IDLE: obf_in=0, obf_reset=1. When start=1 at edge T0, go to RST_HOLD.
// - RST_HOLD: obf_reset=1, busy=1, obf_in=0. It lasts exactly RST_CYCLES cycles.
//   - At edge T0+RST_CYCLES: state=KEY, obf_reset=0, obf_in=step0.
// - KEY: at edge T0+RST_CYCLES+k, obf_in=step k, for k = 0..KEY_LEN-1; busy=1.
//   - func_in is ignored in this state.
// - PASS: entered at edge T0+RST_CYCLES+KEY_LEN; done=1, busy=0, obf_reset=0.
//   - obf_in = func_in sampled at each edge (1-cycle latency).
//   - PASS stays until the next start or reset.
// - start=1 in any state (including RST_HOLD, KEY, PASS) restarts at RST_HOLD:
//   - counter cleared, obf_reset=1, obf_in=0, done=0 at that edge.
// - start held high: each edge re-triggers, so the block stays in RST_HOLD until start falls.
// - Counter width is clog2(max(RST_CYCLES,KEY_LEN)+1).
//   - The counter is reused across phases and cleared on every phase change; it never wraps.
// - KEY_LEN=1: KEY lasts exactly one cycle.
// - Asynchronous reset mid-sequence: immediately forces the reset values.
//   - obf_reset rises asynchronously, so the locked FSM is also re-reset.
// STRUCTURE
// - Package fsm_unlock_pkg holds:
//   - state enum IDLE / RST_HOLD / KEY / PASS (2-bit encoding);
//   - a clog2-based counter-width function;
//   - default RST_CYCLES.
// - Sub-module unlock_cycle_counter: load/clear, increment, and a terminal-count flag
//   comparing against a runtime limit (RST_CYCLES-1 or KEY_LEN-1).
// - Top level holds the state register and output registers only.
// TESTING (IN_W=2, KEY_LEN=4, RST_CYCLES=10, KEY=8'b11_01_10_00)
// 1. Assert reset mid-clock -> obf_reset=1, obf_in=00, busy=0, done=0 immediately, before any edge.
// 2. Pulse start at edge T0 -> obf_reset=1 for edges T0..T0+9;
//    obf_in=00,10,01,11 at T0+10..T0+13; done=1 at T0+14.
// 3. In PASS, drive func_in=10 then 01 -> obf_in=10 and 01, each one edge later;
//    with test_obf attached, outp/overflw match the golden unlocked outputs.
// 4. Pulse start again at T0+12 (mid-KEY) -> obf_reset=1 at that edge;
//    the full 10+4 sequence replays; done=1 at T0+26.
// 5. Hold start high for 5 cycles from IDLE -> RST_HOLD restarts each edge;
//    first key word appears 10 edges after start falls.
// 6. Assert reset during RST_HOLD at count 6 -> IDLE; a later start gives the full 10-cycle hold
//    (no partial count retained).

Source files
------------

// File: rtl/fsm_unlock_pkg.sv
// Shared types and sizing helpers for the locked-FSM unlock sequencer.
package fsm_unlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_KEY      = 2'd2,
    ST_PASS     = 2'd3
  } state_t;

  localparam int DEF_RST_CYCLES = 10;

  // Counter must hold max(RST_CYCLES, KEY_LEN); it never wraps.
  function automatic int cnt_width(input int rst_cycles, input int key_len);
    int m;
    m = (rst_cycles > key_len) ? rst_cycles : key_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/unlock_cycle_counter.sv
// Phase cycle counter: clear, increment, terminal-count against a runtime limit.
module unlock_cycle_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Clear has priority so a phase change always starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CW'(1);
  end

  assign tc = (count == limit);

endmodule

// File: rtl/fsm_unlock_sequencer.sv
// Drives a locked FSM: reset hold, key playback, then functional pass-through.
module fsm_unlock_sequencer
  import fsm_unlock_pkg::*;
#(
  parameter int                    IN_W       = 2,
  parameter int                    KEY_LEN    = 8,
  parameter logic [KEY_LEN*IN_W-1:0] KEY      = '0,
  parameter int                    RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] func_in,
  output logic [IN_W-1:0] obf_in,
  output logic            obf_reset,
  output logic            busy,
  output logic            done
);

  localparam int CW = cnt_width(RST_CYCLES, KEY_LEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, limit;
  logic            cnt_clr, cnt_inc, cnt_tc;
  logic [IN_W-1:0] key_word, obf_in_nxt;
  logic            obf_reset_nxt, busy_nxt, done_nxt;

  // Terminal count depends on which phase is being timed.
  always_comb begin
    limit = (state == ST_KEY) ? CW'(KEY_LEN - 1) : CW'(RST_CYCLES - 1);
  end

  unlock_cycle_counter #(.CW(CW)) u_cnt (
    .clk   (clock),
    .rst   (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (limit),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Key word for the step after the current one (step 0 is loaded on KEY entry).
  always_comb begin
    key_word = '0;
    for (int i = 1; i < KEY_LEN; i++)
      if (cnt == CW'(i - 1)) key_word = KEY[IN_W*i +: IN_W];
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, counter control and next output values; start overrides everything.
  always_comb begin
    state_nxt     = state;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    obf_in_nxt    = '0;
    obf_reset_nxt = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    if (start) begin
      state_nxt     = ST_RST_HOLD;
      cnt_clr       = 1'b1;
      obf_reset_nxt = 1'b1;
      busy_nxt      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: obf_reset_nxt = 1'b1;
        ST_RST_HOLD: begin
          busy_nxt = 1'b1;
          if (cnt_tc) begin
            state_nxt  = ST_KEY;
            cnt_clr    = 1'b1;
            obf_in_nxt = KEY[IN_W-1:0];
          end else begin
            cnt_inc       = 1'b1;
            obf_reset_nxt = 1'b1;
          end
        end
        ST_KEY: begin
          if (cnt_tc) begin
            state_nxt  = ST_PASS;
            cnt_clr    = 1'b1;
            obf_in_nxt = func_in;
            done_nxt   = 1'b1;
          end else begin
            cnt_inc    = 1'b1;
            obf_in_nxt = key_word;
            busy_nxt   = 1'b1;
          end
        end
        ST_PASS: begin
          obf_in_nxt = func_in;
          done_nxt   = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs; reset raises obf_reset asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      obf_in    <= '0;
      obf_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      obf_in    <= obf_in_nxt;
      obf_reset <= obf_reset_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_unlock_sequencer.sv
// Bench for fsm_unlock_sequencer: directed scenarios plus random start/func_in/reset
// traffic, every cycle compared against an elapsed-edges model.
module tb_fsm_unlock_sequencer;

  localparam int IN_W       = 2;
  localparam int KEY_LEN    = 4;
  localparam int RST_CYCLES = 10;
  localparam logic [KEY_LEN*IN_W-1:0] KEY = 8'b11_01_10_00;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [IN_W-1:0] func_in = '0;
  logic [IN_W-1:0] obf_in;
  logic            obf_reset, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  fsm_unlock_sequencer #(
    .IN_W(IN_W), .KEY_LEN(KEY_LEN), .KEY(KEY), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .func_in(func_in),
    .obf_in(obf_in), .obf_reset(obf_reset), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Model: edges elapsed since the last start edge decide every output.
  bit              m_started = 0;
  int              m_e = 0;
  logic [IN_W-1:0] m_func = '0;
  logic [KEY_LEN*IN_W-1:0] key_v = KEY;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_started = 0; m_e = 0; m_func = '0;
    end else begin
      if (start) begin
        m_started = 1; m_e = 0;
      end else if (m_started && m_e < RST_CYCLES + KEY_LEN) begin
        m_e = m_e + 1;
      end
      m_func = func_in;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    logic [IN_W-1:0] e_in;
    logic e_rst, e_busy, e_done;
    e_in = '0; e_rst = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (m_started) begin
      if (m_e < RST_CYCLES) begin
        e_busy = 1'b1;
      end else if (m_e < RST_CYCLES + KEY_LEN) begin
        e_rst = 1'b0; e_busy = 1'b1;
        e_in = key_v[IN_W*(m_e - RST_CYCLES) +: IN_W];
      end else begin
        e_rst = 1'b0; e_done = 1'b1; e_in = m_func;
      end
    end
    chk("model_obf_in",    8'(obf_in),    8'(e_in));
    chk("model_obf_reset", 8'(obf_reset), 8'(e_rst));
    chk("model_busy",      8'(busy),      8'(e_busy));
    chk("model_done",      8'(done),      8'(e_done));
  end

  // One clock: apply inputs, take the edge, return just after the following negedge.
  task automatic cyc(input logic s, input logic [IN_W-1:0] f);
    start = s; func_in = f;
    @(posedge clock); @(negedge clock); #1;
  endtask

  // Reset asserted mid-cycle; outputs must move before any edge.
  task automatic async_rst(input bit check);
    @(posedge clock); #3; reset = 1'b1; #1;
    if (check) begin
      chk("async_obf_reset", 8'(obf_reset), 8'h1);
      chk("async_obf_in",    8'(obf_in),    8'h0);
      chk("async_busy",      8'(busy),      8'h0);
      chk("async_done",      8'(done),      8'h0);
    end
    @(negedge clock); #1; reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("reset_obf_reset", 8'(obf_reset), 8'h1);
    chk("reset_busy",      8'(busy),      8'h0);
    reset = 1'b0;
    cyc(0, 2'b00);

    // Full sequence with literal key words.
    cyc(1, 2'b00);
    chk("t0_obf_reset", 8'(obf_reset), 8'h1);
    for (int i = 1; i <= 9; i++) cyc(0, 2'b11);
    chk("t9_obf_reset", 8'(obf_reset), 8'h1);
    cyc(0, 2'b11); chk("t10_obf_in", 8'(obf_in), 8'h0); chk("t10_obf_reset", 8'(obf_reset), 8'h0);
    cyc(0, 2'b11); chk("t11_obf_in", 8'(obf_in), 8'h2);
    cyc(0, 2'b11); chk("t12_obf_in", 8'(obf_in), 8'h1);
    cyc(0, 2'b00); chk("t13_obf_in", 8'(obf_in), 8'h3); chk("t13_done", 8'(done), 8'h0);
    cyc(0, 2'b00); chk("t14_done", 8'(done), 8'h1);

    // Pass-through, one edge of latency.
    cyc(0, 2'b10); chk("pass_10", 8'(obf_in), 8'h2);
    cyc(0, 2'b01); chk("pass_01", 8'(obf_in), 8'h1);

    // Asynchronous reset while in PASS.
    async_rst(1);
    cyc(0, 2'b00);

    // Restart mid-KEY at T0+12.
    cyc(1, 2'b00);
    for (int i = 1; i <= 11; i++) cyc(0, 2'b00);
    cyc(1, 2'b00);
    chk("restart_obf_reset", 8'(obf_reset), 8'h1);
    chk("restart_done",      8'(done),      8'h0);
    for (int i = 13; i <= 25; i++) cyc(0, 2'b00);
    chk("t25_done", 8'(done), 8'h0);
    cyc(0, 2'b00);
    chk("t26_done", 8'(done), 8'h1);

    // Start held for 5 cycles from IDLE.
    async_rst(0);
    for (int i = 0; i < 5; i++) cyc(1, 2'b00);
    for (int i = 1; i <= 9; i++) cyc(0, 2'b00);
    chk("hold_l9_obf_reset", 8'(obf_reset), 8'h1);
    cyc(0, 2'b00);
    chk("hold_l10_obf_reset", 8'(obf_reset), 8'h0);
    chk("hold_l10_busy",      8'(busy),      8'h1);

    // Reset at hold count 6, then a fresh full hold.
    cyc(1, 2'b00);
    for (int i = 1; i <= 6; i++) cyc(0, 2'b00);
    async_rst(1);
    cyc(1, 2'b00);
    for (int i = 1; i <= 9; i++) cyc(0, 2'b00);
    chk("rehold_t9_obf_reset", 8'(obf_reset), 8'h1);
    cyc(0, 2'b00);
    chk("rehold_t10_obf_reset", 8'(obf_reset), 8'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_rst(1);
      else cyc(1'($urandom_range(0, 39) == 0), IN_W'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
